// File: rtl/dmem_apb_arbiter.sv
// dmem_apb_arbiter
// Shares one APB data-memory slave between the pipeline load/store port (P)
// and the program/debug loader port (L). Round-robin arbitration, APB
// IDLE/SETUP/ACCESS sequencing, a pipeline stall output and a wait-state
// timeout that aborts a transfer the slave never acknowledges.
//
// Requester handshake (both ports): req is a level held together with
// write/addr/wdata until the port's ready pulses for exactly one cycle.
// Request fields are captured at grant, so later changes are ignored until
// the next grant. While ready is high the same port is not eligible, so a
// request still held in its ready cycle is taken as a new request only on
// the following cycle. err is meaningful only alongside a ready pulse.
module dmem_apb_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,

    // pipeline port
    input  logic              p_req,
    input  logic              p_write,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_ready,
    output logic              stall,

    // loader port
    input  logic              l_req,
    input  logic              l_write,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_ready,

    // transfer status, valid with either ready pulse
    output logic              err,

    // APB master
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,

    // FSM state for observation: 0=IDLE 1=SETUP 2=ACCESS
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // MAX_WAIT is limited to 255, so an 8-bit wait counter always suffices.
    localparam int               CNT_W      = 8;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    state_t             state_q;
    state_t             state_d;

    // 1 = the loader owned the most recent grant
    logic               last_l;
    // 1 = the transfer in flight belongs to the loader
    logic               owner_l;
    logic [CNT_W-1:0]   wait_cnt;

    logic               p_eligible;
    logic               l_eligible;
    logic               grant_en;
    logic               grant_l;

    logic               in_access;
    logic               wait_expired;
    logic               xfer_done;
    logic               xfer_fail;
    logic               rdata_update;
    logic [DATA_W-1:0]  rdata_next;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Pick a winner among eligible requesters; a tie goes to the port that
    // did not win last time.
    always_comb begin
        p_eligible = p_req & ~p_ready;
        l_eligible = l_req & ~l_ready;
        grant_en   = (state_q == ST_IDLE) & (p_eligible | l_eligible);
        if (p_eligible & l_eligible) begin
            grant_l = ~last_l;
        end else begin
            grant_l = l_eligible;
        end
    end

    // ------------------------------------------------------------------
    // Transfer termination
    // ------------------------------------------------------------------

    // Decide whether this ACCESS cycle ends the transfer and how it ends.
    always_comb begin
        in_access    = (state_q == ST_ACCESS);
        wait_expired = in_access & ~pready & (wait_cnt == WAIT_LIMIT);
        xfer_done    = in_access & (pready | wait_expired);
        xfer_fail    = wait_expired | (in_access & pready & pslverr);
        // Loads update rdata on success (slave data) or on timeout (zero);
        // a slave error leaves the previous value in place.
        rdata_update = xfer_done & ~pwrite & (wait_expired | ~pslverr);
        rdata_next   = wait_expired ? '0 : prdata;
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------

    // State register; reset abandons any transfer without a completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one SETUP cycle, then ACCESS until ready or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (xfer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // APB control decoded from the registered state, so it is glitch-free.
    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        case (state_q)
            ST_SETUP: begin
                psel = 1'b1;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: begin
                psel    = 1'b0;
                penable = 1'b0;
            end
        endcase
        fsm_state = state_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Capture the winner's request at grant; held stable for the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            owner_l <= 1'b0;
            last_l  <= 1'b1;
        end else if (grant_en) begin
            owner_l <= grant_l;
            last_l  <= grant_l;
            if (grant_l) begin
                pwrite <= l_write;
                paddr  <= l_addr;
                pwdata <= l_wdata;
            end else begin
                pwrite <= p_write;
                paddr  <= p_addr;
                pwdata <= p_wdata;
            end
        end
    end

    // Count ACCESS cycles without pready; cleared whenever ACCESS is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (in_access & ~xfer_done) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // One-cycle completion pulse, status and load data for the owning port.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_ready <= 1'b0;
            l_ready <= 1'b0;
            err     <= 1'b0;
            p_rdata <= '0;
            l_rdata <= '0;
        end else begin
            p_ready <= xfer_done & ~owner_l;
            l_ready <= xfer_done & owner_l;
            err     <= xfer_done & xfer_fail;
            if (rdata_update & ~owner_l) begin
                p_rdata <= rdata_next;
            end
            if (rdata_update & owner_l) begin
                l_rdata <= rdata_next;
            end
        end
    end

    // The pipeline is held for as long as its request is outstanding.
    always_comb begin
        stall = p_req & ~p_ready;
    end

endmodule

// File: tb/tb_dmem_apb_arbiter.sv
// tb_dmem_apb_arbiter
// Drives both requester ports, models an APB slave with programmable wait
// states / error / hang, and checks completions against an expected queue.
module tb_dmem_apb_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int MW = 15;
    localparam int EW = 2 + DW;   // {port, err, rdata}

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          p_req = 1'b0, p_write = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [DW-1:0] p_rdata;
    logic          p_ready, stall;
    logic          l_req = 1'b0, l_write = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic [DW-1:0] l_rdata;
    logic          l_ready, err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0, pslverr = 1'b0;
    logic [1:0]    fsm_state;

    dmem_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready), .stall(stall),
        .l_req(l_req), .l_write(l_write), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rdata(l_rdata), .l_ready(l_ready),
        .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] model_rd[2];
    logic [DW-1:0] ref_mem[64];
    logic [DW-1:0] slv_mem[64];

    int   slave_wait = 0;
    bit   slave_err  = 1'b0;
    bit   slave_hang = 1'b0;
    int   acc_cnt    = 0;
    logic          s_write;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int port, input logic req, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (port == 0) begin
            p_req = req; p_write = wr; p_addr = a; p_wdata = wd;
        end else begin
            l_req = req; l_write = wr; l_addr = a; l_wdata = wd;
        end
    endtask

    // kind: 0 = ok, 1 = slave error, 2 = timeout
    task automatic push_exp(input int port, input logic wr, input int kind, input logic [DW-1:0] ld);
        if (!wr) begin
            if (kind == 0) model_rd[port] = ld;
            else if (kind == 2) model_rd[port] = '0;
        end
        exp_q.push_back({port[0], kind != 0, model_rd[port]});
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        tick;
        tick;
        rst = 1'b0;
        exp_q.delete();
        model_rd[0] = '0;
        model_rd[1] = '0;
        @(negedge clk);
        check_eq("rst_psel", psel, 0);
        check_eq("rst_penable", penable, 0);
        check_eq("rst_pwrite", pwrite, 0);
        check_eq("rst_paddr", paddr, 0);
        check_eq("rst_pwdata", pwdata, 0);
        check_eq("rst_p_rdata", p_rdata, 0);
        check_eq("rst_l_rdata", l_rdata, 0);
        check_eq("rst_readies", {p_ready, l_ready, err}, 0);
        check_eq("rst_state", fsm_state, S_IDLE);
        tick;
    endtask

    // One complete transfer on one port; checks request-to-ready latency and
    // leaves one idle cycle after the ready pulse.
    task automatic run_xfer(input int port, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int kind, input int exp_lat,
                            input bit wiggle);
        int lat;
        if (wr && kind == 0) ref_mem[a] = wd;
        push_exp(port, wr, kind, ref_mem[a]);
        drive_req(port, 1'b1, wr, a, wd);
        lat = 0;
        while (1) begin
            tick;
            lat++;
            if (wiggle && lat == 2) drive_req(port, 1'b1, ~wr, ~a, ~wd);
            if ((port == 0 ? p_ready : l_ready) || lat >= 40) break;
        end
        check_eq("latency", lat, exp_lat);
        drive_req(port, 1'b0, 1'b0, '0, '0);
        tick;
    endtask

    // ---------------- APB slave model ----------------
    initial begin
        forever begin
            @(negedge clk);
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = DW'($urandom);
            if (psel === 1'b1 && penable === 1'b0) begin
                s_write = pwrite; s_addr = paddr; s_wdata = pwdata;
                acc_cnt = 0;
            end else if (psel === 1'b1 && penable === 1'b1) begin
                check_eq("apb_stable", {pwrite, paddr, pwdata}, {s_write, s_addr, s_wdata});
                if (!slave_hang && acc_cnt >= slave_wait) begin
                    pready  = 1'b1;
                    pslverr = slave_err;
                    if (!pwrite) prdata = slv_mem[paddr];
                    else if (!slave_err) slv_mem[paddr] = pwdata;
                end else begin
                    acc_cnt++;
                end
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_eq("stall", stall, p_req & ~p_ready);
                check_eq("dual_ready", p_ready & l_ready, 0);
                if (!p_ready && !l_ready) check_eq("err_idle", err, 0);
                if (p_ready || l_ready) begin
                    check_eq("ready_has_exp", exp_q.size() != 0, 1);
                    check_eq("psel_at_ready", psel, 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("ready_port", l_ready, e[EW-1]);
                        check_eq("ready_err", err, e[EW-2]);
                        check_eq("ready_rdata", l_ready ? l_rdata : p_rdata, e[DW-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, cyc, first, second, port, w;
        logic wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = DW'(16'hA000 + i * 7);
        end
        ref_mem[5]  = 16'hBEEF;
        ref_mem[10] = 16'h1111;
        ref_mem[20] = 16'h2222;
        ref_mem[9]  = 16'h0909;
        for (int i = 0; i < 64; i++) slv_mem[i] = ref_mem[i];

        // 1: reset values, single P load with cycle-by-cycle bus checks
        do_reset;
        slave_wait = 0;
        push_exp(0, 1'b0, 0, ref_mem[5]);
        drive_req(0, 1'b1, 1'b0, 6'd5, '0);
        @(negedge clk);
        check_eq("c0_state", fsm_state, S_IDLE);
        check_eq("c0_psel", psel, 0);
        tick;
        @(negedge clk);
        check_eq("c1_state", fsm_state, S_SETUP);
        check_eq("c1_bus", {psel, penable}, 2'b10);
        check_eq("c1_stall", stall, 1);
        tick;
        @(negedge clk);
        check_eq("c2_state", fsm_state, S_ACCESS);
        check_eq("c2_bus", {psel, penable, pwrite}, 3'b110);
        check_eq("c2_paddr", paddr, 5);
        tick;
        check_eq("c3_p_ready", p_ready, 1);
        check_eq("c3_p_rdata", p_rdata, 16'hBEEF);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        tick;

        // 2: simultaneous held requests alternate P,L,P,L
        do_reset;
        push_exp(0, 1'b0, 0, ref_mem[10]);
        push_exp(1, 1'b0, 0, ref_mem[20]);
        push_exp(0, 1'b0, 0, ref_mem[10]);
        push_exp(1, 1'b0, 0, ref_mem[20]);
        drive_req(0, 1'b1, 1'b0, 6'd10, '0);
        drive_req(1, 1'b1, 1'b0, 6'd20, '0);
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            tick;
            cyc++;
            if (p_ready || l_ready) n++;
        end
        check_eq("t2_count", n, 4);
        check_eq("t2_cycles", cyc, 12);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        tick;

        // 3: L store with 3 wait states, request fields scrambled mid-transfer
        slave_wait = 3;
        run_xfer(1, 1'b1, 6'd63, 16'h1234, 0, 6, 1'b1);
        check_eq("t3_mem", slv_mem[63], 16'h1234);
        slave_wait = 0;
        run_xfer(1, 1'b0, 6'd63, '0, 0, 3, 1'b0);

        // 4: timeout, then slave errors keep old rdata
        slave_hang = 1'b1;
        run_xfer(0, 1'b0, 6'd7, '0, 2, 3 + MW, 1'b0);
        slave_hang = 1'b0;
        slave_err  = 1'b1;
        run_xfer(0, 1'b0, 6'd8, '0, 1, 3, 1'b0);
        run_xfer(1, 1'b0, 6'd11, '0, 1, 3, 1'b0);
        run_xfer(1, 1'b1, 6'd12, 16'h5555, 1, 3, 1'b0);
        check_eq("t4_no_store", slv_mem[12], ref_mem[12]);
        slave_err = 1'b0;

        // 5: reset during ACCESS, held request then serviced normally
        slave_wait = 5;
        drive_req(0, 1'b1, 1'b0, 6'd9, '0);
        tick;
        tick;
        check_eq("t5_state_pre", fsm_state, S_ACCESS);
        rst = 1'b1;
        tick;
        check_eq("t5_bus", {psel, penable}, 0);
        check_eq("t5_ready", {p_ready, l_ready, err}, 0);
        check_eq("t5_state", fsm_state, S_IDLE);
        rst = 1'b0;
        slave_wait = 0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        push_exp(0, 1'b0, 0, ref_mem[9]);
        cyc = 0;
        while (1) begin
            tick;
            cyc++;
            if (p_ready || cyc >= 40) break;
        end
        check_eq("t5_latency", cyc, 3);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        tick;

        // 6: P held across its ready cycle gives one transfer per ready
        push_exp(0, 1'b0, 0, ref_mem[5]);
        push_exp(0, 1'b0, 0, ref_mem[5]);
        drive_req(0, 1'b1, 1'b0, 6'd5, '0);
        n = 0; first = 0; second = 0;
        for (int c = 1; c <= 7; c++) begin
            tick;
            if (p_ready) begin
                n++;
                if (n == 1) first = c;
                else second = c;
            end
        end
        check_eq("t6_count", n, 2);
        check_eq("t6_first", first, 3);
        check_eq("t6_second", second, 7);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            tick;
            check_eq("t6_idle_bus", {psel, p_ready}, 0);
        end

        // random single transfers
        for (int i = 0; i < 12; i++) begin
            port = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            a    = AW'($urandom_range(0, 63));
            wd   = DW'($urandom);
            w    = $urandom_range(0, 4);
            slave_wait = w;
            run_xfer(port, wr, a, wd, 0, 3 + w, 1'b0);
        end

        tick;
        check_eq("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
